// File: rtl/noc_pkg.sv
// Shared constants and FSM encoding for the NoC link arbiter.
// Credit counter width covers CREDITS up to 7.
package noc_pkg;

  localparam int DATA_W_DEF  = 20;
  localparam int CREDITS_DEF = 4;
  localparam int CRED_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/noc_rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, cyclic.
// Purely combinational; no backpressure of its own.
module noc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int               j;
  logic [IDX_W-1:0] sel;

  // Walk offsets from farthest to nearest so the nearest hit overrides.
  always_comb begin
    winner    = rr_ptr;
    any_valid = 1'b0;
    j         = 0;
    sel       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = IDX_W'(j);
      if (req[sel]) begin
        winner    = sel;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_link_arbiter.sv
// Round-robin, credit-tracked arbiter for one NoC output link; valid->ready 1 cycle, ready->out 1 cycle.
// Ready held low with zero credits; NOC_ARB_PKT_LOCK_EN locks the grant for a whole packet (wormhole).
module noc_link_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CREDITS = CREDITS_DEF
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        ci,
  output logic [DATA_W-1:0]           dataout,
  output logic                        out_valid,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [CRED_W-1:0]           credit_cnt,
  output logic                        credit_err
);

  localparam int                IDX_W    = $clog2(NUM_REQ);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic             xfer;
  logic             pkt_end;

  noc_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign xfer = req_valid[grant_id] & req_ready[grant_id];

`ifdef NOC_ARB_PKT_LOCK_EN
  assign pkt_end = xfer & req_last[grant_id];
`else
  // Every flit is its own arbitration unit, so tail markers carry no meaning.
  logic unused_last;
  assign unused_last = ^req_last;
  assign pkt_end     = xfer;
`endif

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: if (any_valid) state_nxt = BUSY;
      BUSY: begin
        req_ready[grant_id] = (credit_cnt != '0);
        if (pkt_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      credit_cnt <= CRED_MAX;
      dataout    <= '0;
      out_valid  <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= xfer;
      if (state == IDLE && any_valid) grant_id <= winner;
      if (pkt_end) rr_ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
      if (xfer) dataout <= req_data[int'(grant_id)*DATA_W +: DATA_W];
      // A return while already full means the downstream side lost count.
      if (ci && credit_cnt == CRED_MAX) credit_err <= 1'b1;
      if (xfer && !ci)
        credit_cnt <= credit_cnt - 1'b1;
      else if (ci && !xfer && credit_cnt != CRED_MAX)
        credit_cnt <= credit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Directed and randomized checks of noc_link_arbiter against a per-requester queue model.
// Expected order comes from round-robin over non-empty queues; credits from sent/returned counts.
module tb_noc_link_arbiter;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int CR = 4;

  logic            clk = 1'b0;
  logic            RST = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic            ci = 1'b0;
  logic [DW-1:0]   dataout;
  logic            out_valid;
  logic [1:0]      grant_id;
  logic [2:0]      credit_cnt;
  logic            credit_err;

  noc_link_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CREDITS(CR)) dut (
    .clk        (clk),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .ci         (ci),
    .dataout    (dataout),
    .out_valid  (out_valid),
    .grant_id   (grant_id),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq [N][$];
  bit            lq [N][$];
  int            src_log [$];
  int            t_log [$];
  int            ptr, in_pkt, cur_src, sent, ret, cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (fq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = fq[i][0];
        req_last[i]          = lq[i][0];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic add_pkt(input int q, input int len);
    for (int f = 0; f < len; f++) begin
      fq[q].push_back(DW'($urandom));
      lq[q].push_back(f == len - 1);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      lq[i].delete();
    end
    src_log.delete();
    t_log.delete();
    ptr = 0; in_pkt = 0; cur_src = 0; sent = 0; ret = 0; cyc = 0;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b0;
    ci  = 1'b0;
    model_clear();
    drive_reqs();
    repeat (n) @(posedge clk);
    #1;
    RST = 1'b1;
  endtask

  // One call = up to 'cycles' clock cycles; every emitted flit is matched against the model.
  task automatic run(input int cycles, input int ci_pct, input int ci_limit,
                     input int stop_sent, input int stop_cred);
    int given = 0;
    int cur;
    int j;
    logic [DW-1:0] exp;
`ifdef NOC_ARB_PKT_LOCK_EN
    bit l;
`endif
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        cur = -1;
        if (in_pkt != 0) cur = cur_src;
        else begin
          for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (cur < 0 && fq[j].size() > 0) cur = j;
          end
        end
        if (cur < 0) chk("spurious_flit", 32'(out_valid), 0);
        else begin
          exp = fq[cur].pop_front();
`ifdef NOC_ARB_PKT_LOCK_EN
          l = lq[cur].pop_front();
          if (l) begin ptr = (cur + 1) % N; in_pkt = 0; end
          else begin in_pkt = 1; cur_src = cur; end
`else
          void'(lq[cur].pop_front());
          ptr = (cur + 1) % N;
`endif
          chk("flit_data", 32'(dataout), 32'(exp));
          chk("flit_src", 32'(grant_id), cur);
          src_log.push_back(cur);
          t_log.push_back(cyc);
          sent++;
        end
      end
      chk("credit_cnt", 32'(credit_cnt), CR - sent + ret);
      if (sent - ret > 0 && given < ci_limit && $urandom_range(1, 100) <= ci_pct) begin
        ci = 1'b1; ret++; given++;
      end else ci = 1'b0;
      drive_reqs();
      cyc++;
      if (stop_sent >= 0 && src_log.size() >= stop_sent) break;
      if (stop_cred >= 0 && int'(credit_cnt) == stop_cred && req_ready != '0) break;
    end
  endtask

  initial begin
    int e2 [5];
    int e5 [5];
    int total;

    // Reset values
    do_reset(2);
    chk("rst_credit", 32'(credit_cnt), CR);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_err", 32'(credit_err), 0);
    chk("rst_data", 32'(dataout), 0);

    // Four single-flit requesters, credits returned promptly
    add_pkt(0, 1); add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1);
    drive_reqs();
    run(40, 100, 1000, 5, -1);
    e2 = '{0, 1, 2, 3, 0};
    chk("rr_count", src_log.size(), 5);
    for (int k = 0; k < 5 && k < src_log.size(); k++) chk("rr_order", src_log[k], e2[k]);
    for (int k = 1; k < t_log.size(); k++) chk("rr_spacing", t_log[k] - t_log[k-1], 2);

    // Credit exhaustion and single return
    do_reset(1);
    add_pkt(0, 6);
    drive_reqs();
    run(20, 0, 0, -1, -1);
    chk("cred_stall_count", src_log.size(), 4);
    chk("cred_stall_cnt", 32'(credit_cnt), 0);
    chk("cred_stall_ready", 32'(req_ready), 0);
    run(10, 100, 1, -1, -1);
    chk("cred_one_more", src_log.size(), 5);
    chk("cred_zero_again", 32'(credit_cnt), 0);
    run(60, 100, 1000, -1, -1);
    chk("cred_drained", fq[0].size(), 0);
    chk("cred_refilled", 32'(credit_cnt), CR);

    // Transfer and return in the same cycle, then an over-return
    add_pkt(0, 10);
    drive_reqs();
    run(50, 0, 0, -1, 2);
    ci = 1'b1;
    ret++;
    run(1, 0, 0, -1, -1);
    chk("same_cycle_cnt", 32'(credit_cnt), 2);
    chk("same_cycle_xfer", 32'(out_valid), 1);
    run(100, 100, 1000, -1, -1);
    chk("same_cycle_drained", fq[0].size(), 0);
    chk("err_before", 32'(credit_err), 0);
    ci = 1'b1;
    @(posedge clk);
    #1;
    ci = 1'b0;
    chk("over_return_err", 32'(credit_err), 1);
    chk("over_return_cnt", 32'(credit_cnt), CR);

    // Packet locking versus per-flit interleave
    do_reset(1);
    add_pkt(1, 3);
    add_pkt(2, 2);
    drive_reqs();
    run(60, 100, 1000, 5, -1);
`ifdef NOC_ARB_PKT_LOCK_EN
    e5 = '{1, 1, 1, 2, 2};
`else
    e5 = '{1, 2, 1, 2, 1};
`endif
    chk("lock_count", src_log.size(), 5);
    for (int k = 0; k < 5 && k < src_log.size(); k++) chk("lock_order", src_log[k], e5[k]);

    // Reset in the middle of a packet
    do_reset(1);
    add_pkt(3, 5);
    drive_reqs();
    run(50, 100, 1000, 2, -1);
    chk("midrst_sent", src_log.size(), 2);
    RST = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_credit", 32'(credit_cnt), CR);
    chk("midrst_ready", 32'(req_ready), 0);
    chk("midrst_grant", 32'(grant_id), 0);

    // Randomized traffic with random credit returns
    for (int r = 0; r < 4; r++) begin
      do_reset(1);
      total = 0;
      for (int i = 0; i < N; i++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 4);
          add_pkt(i, len);
          total += len;
        end
      end
      if (total == 0) begin add_pkt(0, 1); total = 1; end
      drive_reqs();
      run(4000, 50, 1 << 30, total, -1);
      chk("rand_count", src_log.size(), total);
      run(50, 100, 1000, -1, -1);
      chk("rand_credit", 32'(credit_cnt), CR);
      chk("rand_err", 32'(credit_err), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
